// File: rtl/bowling_round_ctrl_pkg.sv
// Shared definitions for the bowling round sequencer: state encoding (also used
// for the LED debug mapping), default target seed and the target LFSR step.
package bowling_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AIM    = 3'd1,
        ST_POWER  = 3'd2,
        ST_ROLL   = 3'd3,
        ST_RESULT = 3'd4,
        ST_NEXT   = 3'd5,
        ST_OVER   = 3'd6
    } state_t;

    localparam logic [2:0] TARGET_SEED_DEF = 3'b010;

    // Maximal-length 3-bit sequence; zero is never reached from a nonzero seed.
    function automatic logic [2:0] lfsr_next(input logic [2:0] t);
        return {t[1:0], t[2] ^ t[1]};
    endfunction

endpackage

// File: rtl/bowling_round_ctrl_target_lfsr.sv
// Per-round target pin generator: 3-bit LFSR advanced once per round.
module target_lfsr
    import bowling_defs::*;
#(
    parameter logic [2:0] SEED = TARGET_SEED_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       step,
    output logic [2:0] target
);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            target <= SEED;
        else if (step)
            target <= lfsr_next(target);
    end

endmodule

// File: rtl/bowling_round_ctrl.sv
// Round sequencer: walks each frame through aim, power, roll, result delay and
// advance; all outputs registered, pulses high for the first cycle of a state.
module bowling_round_ctrl
    import bowling_defs::*;
#(
    parameter int         FRAMES       = 10,
    parameter int         DELAY_TICKS  = 2,
    parameter int         ROLL_TIMEOUT = 8,
    parameter logic [2:0] TARGET_SEED  = TARGET_SEED_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       start,
    input  logic       aim_confirm,
    input  logic       power_hold,
    input  logic       pin_hit,
    input  logic       pin_miss,
    output logic       aim_en,
    output logic       power_en,
    output logic       pin_start,
    output logic       round_reset,
    output logic       game_reset,
    output logic [2:0] target,
    output logic [3:0] frame,
    output logic       last_hit,
    output logic       game_over,
    output logic [2:0] state
);

    state_t     st_q, st_d;
    logic [3:0] frame_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic       seen_hold_q, seen_hold_d;
    logic       last_hit_d;
    logic       pin_start_d, game_reset_d;

    target_lfsr #(.SEED(TARGET_SEED)) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .step     (st_q == ST_NEXT),
        .target   (target)
    );

    always_comb begin
        st_d         = st_q;
        frame_d      = frame;
        tick_cnt_d   = tick_cnt_q;
        seen_hold_d  = seen_hold_q;
        last_hit_d   = last_hit;
        pin_start_d  = 1'b0;
        game_reset_d = 1'b0;
        case (st_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    st_d         = ST_AIM;
                    frame_d      = 4'd1;
                    game_reset_d = 1'b1;
                end
            end
            ST_AIM: begin
                seen_hold_d = 1'b0;
                if (aim_confirm)
                    st_d = ST_POWER;
            end
            ST_POWER: begin
                if (power_hold)
                    seen_hold_d = 1'b1;
                else if (seen_hold_q) begin
                    st_d        = ST_ROLL;
                    pin_start_d = 1'b1;
                    seen_hold_d = 1'b0;
                    tick_cnt_d  = 4'd0;
                end
            end
            ST_ROLL: begin
                if (tick_1s)
                    tick_cnt_d = tick_cnt_q + 4'd1;
                // Hit outranks miss, and any verdict outranks the timeout.
                if (pin_hit || pin_miss ||
                    (tick_1s && tick_cnt_q == 4'(ROLL_TIMEOUT - 1))) begin
                    st_d       = ST_RESULT;
                    last_hit_d = pin_hit;
                    tick_cnt_d = 4'd0;
                end
            end
            ST_RESULT: begin
                if (tick_1s) begin
                    if (tick_cnt_q == 4'(DELAY_TICKS - 1))
                        st_d = ST_NEXT;
                    else
                        tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
            ST_NEXT: begin
                if (frame == 4'(FRAMES))
                    st_d = ST_OVER;
                else begin
                    st_d    = ST_AIM;
                    frame_d = frame + 4'd1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            st_q        <= ST_IDLE;
            frame       <= 4'd0;
            tick_cnt_q  <= 4'd0;
            seen_hold_q <= 1'b0;
            last_hit    <= 1'b0;
            aim_en      <= 1'b0;
            power_en    <= 1'b0;
            pin_start   <= 1'b0;
            round_reset <= 1'b0;
            game_reset  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            st_q        <= st_d;
            frame       <= frame_d;
            tick_cnt_q  <= tick_cnt_d;
            seen_hold_q <= seen_hold_d;
            last_hit    <= last_hit_d;
            // Level outputs follow the next state so they line up with it.
            aim_en      <= (st_d == ST_AIM);
            power_en    <= (st_d == ST_POWER);
            pin_start   <= pin_start_d;
            round_reset <= (st_d == ST_NEXT);
            game_reset  <= game_reset_d;
            game_over   <= (st_d == ST_OVER);
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_bowling_round_ctrl.sv
// Directed bench for bowling_round_ctrl with hand-computed expectations.
module tb_bowling_round_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset, tick_1s, start, aim_confirm, power_hold, pin_hit, pin_miss;
    logic       aim_en, power_en, pin_start, round_reset, game_reset;
    logic [2:0] target;
    logic [3:0] frame;
    logic       last_hit, game_over;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] seq [7];

    bowling_round_ctrl dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .tick_1s     (tick_1s),
        .start       (start),
        .aim_confirm (aim_confirm),
        .power_hold  (power_hold),
        .pin_hit     (pin_hit),
        .pin_miss    (pin_miss),
        .aim_en      (aim_en),
        .power_en    (power_en),
        .pin_start   (pin_start),
        .round_reset (round_reset),
        .game_reset  (game_reset),
        .target      (target),
        .frame       (frame),
        .last_hit    (last_hit),
        .game_over   (game_over),
        .state       (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
    endtask

    // One frame from AIM through NEXT; returns one cycle after NEXT.
    task automatic play_round(input logic hit);
        aim_confirm = 1'b1; cyc(); aim_confirm = 1'b0;
        power_hold = 1'b1;  cyc(); power_hold = 1'b0;
        cyc();
        chk("round_roll", 8'(state), 8'd3);
        if (hit) pin_hit = 1'b1; else pin_miss = 1'b1;
        cyc();
        pin_hit = 1'b0; pin_miss = 1'b0;
        chk("round_last_hit", 8'(last_hit), 8'(hit));
        tick();
        tick();
        chk("round_next", 8'(state), 8'd5);
        cyc();
    endtask

    initial begin
        seq[0] = 3'b010; seq[1] = 3'b101; seq[2] = 3'b011; seq[3] = 3'b111;
        seq[4] = 3'b110; seq[5] = 3'b100; seq[6] = 3'b001;
        reset = 1'b0; tick_1s = 1'b0; start = 1'b0; aim_confirm = 1'b0;
        power_hold = 1'b0; pin_hit = 1'b0; pin_miss = 1'b0;
        cyc(2);
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_frame", 8'(frame), 8'd0);
        chk("rst_target", 8'(target), 8'h2);
        chk("rst_outs", 8'({aim_en, power_en, pin_start, round_reset, game_reset, last_hit, game_over}), 8'd0);
        reset = 1'b1;
        cyc();

        // start
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_state", 8'(state), 8'd1);
        chk("start_game_reset", 8'(game_reset), 8'd1);
        chk("start_frame", 8'(frame), 8'd1);
        chk("start_aim_en", 8'(aim_en), 8'd1);
        chk("start_target", 8'(target), 8'h2);
        cyc();
        chk("game_reset_once", 8'(game_reset), 8'd0);

        // frame 1: release without hold ignored, then hold 5 and release
        aim_confirm = 1'b1; cyc(); aim_confirm = 1'b0;
        chk("power_en", 8'(power_en), 8'd1);
        chk("aim_en_off", 8'(aim_en), 8'd0);
        cyc(2);
        chk("nohold_state", 8'(state), 8'd2);
        chk("nohold_pin_start", 8'(pin_start), 8'd0);
        power_hold = 1'b1; cyc(5); power_hold = 1'b0;
        chk("hold_state", 8'(state), 8'd2);
        cyc();
        chk("release_state", 8'(state), 8'd3);
        chk("release_pin_start", 8'(pin_start), 8'd1);
        chk("release_power_en", 8'(power_en), 8'd0);
        cyc();
        chk("pin_start_once", 8'(pin_start), 8'd0);
        cyc();
        pin_hit = 1'b1; pin_miss = 1'b1; cyc(); pin_hit = 1'b0; pin_miss = 1'b0;
        chk("both_result", 8'(state), 8'd4);
        chk("both_last_hit", 8'(last_hit), 8'd1);
        tick();
        chk("tick1_state", 8'(state), 8'd4);
        cyc();
        tick();
        chk("tick2_state", 8'(state), 8'd5);
        chk("round_reset", 8'(round_reset), 8'd1);
        chk("next_target", 8'(target), 8'h2);
        cyc();
        chk("adv_state", 8'(state), 8'd1);
        chk("adv_aim_en", 8'(aim_en), 8'd1);
        chk("round_reset_once", 8'(round_reset), 8'd0);
        chk("adv_frame", 8'(frame), 8'd2);
        chk("adv_target", 8'(target), 8'h5);

        // frame 2: roll timeout, stray start ignored in ROLL
        aim_confirm = 1'b1; cyc(); aim_confirm = 1'b0;
        power_hold = 1'b1;  cyc(); power_hold = 1'b0;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_in_roll", 8'(state), 8'd3);
        chk("start_in_roll_gr", 8'(game_reset), 8'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            cyc();
        end
        chk("to_7_ticks", 8'(state), 8'd3);
        tick();
        chk("to_result", 8'(state), 8'd4);
        chk("to_last_hit", 8'(last_hit), 8'd0);
        tick();
        tick();
        chk("to_next", 8'(state), 8'd5);
        cyc();
        chk("to_frame", 8'(frame), 8'd3);
        chk("to_target", 8'(target), 8'h3);

        // frames 3..9
        for (int f = 3; f <= 9; f++) begin
            play_round(f[0]);
            chk("loop_state", 8'(state), 8'd1);
            chk("loop_frame", 8'(frame), 8'(f + 1));
            chk("loop_target", 8'(target), 8'(seq[f % 7]));
        end
        play_round(1'b1);
        chk("over_state", 8'(state), 8'd6);
        chk("over_flag", 8'(game_over), 8'd1);
        chk("over_frame", 8'(frame), 8'd10);
        chk("over_target", 8'(target), 8'h7);
        aim_confirm = 1'b1; cyc(); aim_confirm = 1'b0;
        chk("over_ignore_aim", 8'(state), 8'd6);
        chk("over_frame_hold", 8'(frame), 8'd10);

        // restart from OVER
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_state", 8'(state), 8'd1);
        chk("restart_frame", 8'(frame), 8'd1);
        chk("restart_game_reset", 8'(game_reset), 8'd1);
        chk("restart_game_over", 8'(game_over), 8'd0);
        chk("restart_target", 8'(target), 8'h7);

        // reset mid-ROLL
        aim_confirm = 1'b1; cyc(); aim_confirm = 1'b0;
        power_hold = 1'b1;  cyc(); power_hold = 1'b0;
        cyc();
        chk("pre_reset_roll", 8'(state), 8'd3);
        reset = 1'b0;
        #1;
        chk("async_state", 8'(state), 8'd0);
        chk("async_frame", 8'(frame), 8'd0);
        chk("async_target", 8'(target), 8'h2);
        chk("async_outs", 8'({aim_en, power_en, pin_start, round_reset, game_reset, last_hit, game_over}), 8'd0);
        cyc();
        reset = 1'b1;
        pin_hit = 1'b1; cyc(); pin_hit = 1'b0;
        chk("idle_pin_hit_state", 8'(state), 8'd0);
        chk("idle_pin_hit_last", 8'(last_hit), 8'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
